// File: rtl/matrix_link_rx.sv
// -----------------------------------------------------------------------------
// matrix_link_rx
//   Receiver for the matrix transmitter link. Two independent serial paths
//   arrive on asynchronous lines and are oversampled on clk:
//     * a multi-lane SPI path (spi_clk + CHANNEL_NUMBER MOSI lanes) that
//       carries BYTES_PER_MATRIX words per lane per frame;
//     * a shift-register/latch path (ser_clk, ser_data, ser_stcp) that
//       delivers column words. A latched column with LSB set marks the start
//       of a new frame.
//
//   Every link line goes through a 2-flop synchronizer. Link clocks get one
//   more register for edge detection, so a raw edge is acted on at the third
//   clk edge after it; results are presented one clk after that.
//
// Ports
//   clk, rst       : system clock, asynchronous active-high reset
//   spi_clk        : SPI bit clock (rising edge samples MOSI)
//   spi_mosi       : one data line per lane
//   ser_clk        : column shift clock (rising edge shifts ser_data in)
//   ser_data       : column serial data
//   ser_stcp       : column storage strobe (rising edge latches column)
//   ser_n_enable   : transmitter output enable, active low
//   data_out       : received words, lane i at [i*SPI_SIZE +: SPI_SIZE]
//   data_valid     : one-cycle pulse, data_out/byte_index updated
//   byte_index     : index of the word on data_out within the frame
//   frame_start    : one-cycle pulse, latched column carried the start bit
//   frame_done     : one-cycle pulse together with the last word of a frame
//   col_valid      : one-cycle pulse, col_data updated
//   col_data       : last latched column word
//   link_err       : sticky error (word timeout or frame overrun)
//   out_enabled    : synchronized, inverted ser_n_enable
// -----------------------------------------------------------------------------
// Word receiver states
//   state | meaning
//   IDLE  | bit counter at 0, waiting for the first bit of a word
//   RECV  | partial word held, idle timer running
// -----------------------------------------------------------------------------
module matrix_link_rx #(
  parameter int CHANNEL_NUMBER   = 3,
  parameter int SPI_SIZE         = 8,
  parameter int MSB_FIRST        = 1,
  parameter int BYTES_PER_MATRIX = 384,
  parameter int COL_BITS         = 8,
  parameter int IDLE_TIMEOUT     = 1024
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   spi_clk,
  input  logic [CHANNEL_NUMBER-1:0]              spi_mosi,
  input  logic                                   ser_clk,
  input  logic                                   ser_data,
  input  logic                                   ser_stcp,
  input  logic                                   ser_n_enable,
  output logic [CHANNEL_NUMBER*SPI_SIZE-1:0]     data_out,
  output logic                                   data_valid,
  output logic [$clog2(BYTES_PER_MATRIX+1)-1:0]  byte_index,
  output logic                                   frame_start,
  output logic                                   frame_done,
  output logic                                   col_valid,
  output logic [COL_BITS-1:0]                    col_data,
  output logic                                   link_err,
  output logic                                   out_enabled
);

  localparam int IDX_W  = $clog2(BYTES_PER_MATRIX + 1);
  localparam int BIT_W  = $clog2(SPI_SIZE + 1);
  localparam int TMR_W  = $clog2(IDLE_TIMEOUT + 1);
  localparam int LANE_W = CHANNEL_NUMBER * SPI_SIZE;
  localparam int NS     = CHANNEL_NUMBER + 5;

  localparam logic [IDX_W-1:0] LAST_WORD = IDX_W'(BYTES_PER_MATRIX - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(SPI_SIZE - 1);
  localparam logic [TMR_W-1:0] TMR_LOAD  = TMR_W'(IDLE_TIMEOUT - 1);

  typedef enum logic {IDLE, RECV} state_t;

  // ---------------------------------------------------------------------------
  // Synchronizers. Bit map of the packed vector:
  //   0            : spi_clk
  //   CN:1         : spi_mosi
  //   CN+1         : ser_clk
  //   CN+2         : ser_data
  //   CN+3         : ser_stcp
  //   CN+4         : ser_n_enable
  // ---------------------------------------------------------------------------
  logic [NS-1:0]             raw;
  logic [NS-1:0]             sync1;
  logic [NS-1:0]             sync2;
  logic [2:0]                edge_q;
  logic                      spi_s;
  logic                      ser_clk_s;
  logic                      ser_data_s;
  logic                      stcp_s;
  logic                      nen_s;
  logic [CHANNEL_NUMBER-1:0] mosi_s;
  logic                      spi_rise;
  logic                      ser_rise;
  logic                      stcp_rise;

  assign raw = {ser_n_enable, ser_stcp, ser_data, ser_clk, spi_mosi, spi_clk};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1  <= '0;
      sync2  <= '0;
      edge_q <= '0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      edge_q <= {stcp_s, ser_clk_s, spi_s};
    end
  end

  assign spi_s      = sync2[0];
  assign mosi_s     = sync2[CHANNEL_NUMBER:1];
  assign ser_clk_s  = sync2[CHANNEL_NUMBER+1];
  assign ser_data_s = sync2[CHANNEL_NUMBER+2];
  assign stcp_s     = sync2[CHANNEL_NUMBER+3];
  assign nen_s      = sync2[CHANNEL_NUMBER+4];

  // Data lines are taken from the same synchronizer depth as the clock level
  // that produced the edge, so they stay aligned with the sampling edge.
  assign spi_rise  = spi_s     & ~edge_q[0];
  assign ser_rise  = ser_clk_s & ~edge_q[1];
  assign stcp_rise = stcp_s    & ~edge_q[2];

  // ---------------------------------------------------------------------------
  // Receiver state and pipeline
  // ---------------------------------------------------------------------------
  state_t               state;
  logic [BIT_W-1:0]     bit_cnt;
  logic [IDX_W-1:0]     word_cnt;
  logic                 wrapped;      // frame_done seen, no frame_start since
  logic [TMR_W-1:0]     tmr;
  logic [LANE_W-1:0]    lane_sh;
  logic [COL_BITS-1:0]  col_sh;

  // Stage between the detected event and the registered outputs.
  logic                 pend_valid;
  logic [LANE_W-1:0]    pend_data;
  logic [IDX_W-1:0]     pend_idx;
  logic                 pend_done;
  logic                 pend_err;
  logic                 pend_col;
  logic [COL_BITS-1:0]  pend_col_data;
  logic                 pend_fs;

  logic [LANE_W-1:0]    lane_next;
  logic                 wdone;
  logic                 fs_evt;
  logic                 timeout_now;
  logic                 overrun_now;

  always_comb begin
    lane_next = lane_sh;
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      if (MSB_FIRST != 0)
        lane_next[i*SPI_SIZE +: SPI_SIZE] = {lane_sh[i*SPI_SIZE +: SPI_SIZE-1], mosi_s[i]};
      else
        lane_next[i*SPI_SIZE +: SPI_SIZE] = {mosi_s[i], lane_sh[i*SPI_SIZE+1 +: SPI_SIZE-1]};
    end
  end

  // The column register is latched before any same-cycle shift, so the start
  // bit is judged on the word that is actually copied to col_data.
  assign fs_evt      = stcp_rise & col_sh[0];
  assign wdone       = spi_rise & (bit_cnt == LAST_BIT);
  // A word completing in the same cycle as frame_start belongs to the new
  // frame, so it can never be an overrun.
  assign overrun_now = wdone & ~fs_evt & wrapped;
  assign timeout_now = (state == RECV) & ~spi_rise & ~fs_evt & (tmr == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      word_cnt      <= '0;
      wrapped       <= 1'b0;
      tmr           <= '0;
      lane_sh       <= '0;
      col_sh        <= '0;
      pend_valid    <= 1'b0;
      pend_data     <= '0;
      pend_idx      <= '0;
      pend_done     <= 1'b0;
      pend_err      <= 1'b0;
      pend_col      <= 1'b0;
      pend_col_data <= '0;
      pend_fs       <= 1'b0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      byte_index    <= '0;
      frame_start   <= 1'b0;
      frame_done    <= 1'b0;
      col_valid     <= 1'b0;
      col_data      <= '0;
      link_err      <= 1'b0;
      out_enabled   <= 1'b0;
    end else begin
      // -------- output stage --------
      data_valid  <= pend_valid;
      frame_done  <= pend_valid & pend_done;
      col_valid   <= pend_col;
      frame_start <= pend_col & pend_fs;
      out_enabled <= ~nen_s;
      if (pend_valid) begin
        data_out   <= pend_data;
        byte_index <= pend_idx;
      end
      if (pend_col)
        col_data <= pend_col_data;
      if (pend_col && pend_fs)
        link_err <= 1'b0;
      else if (pend_err)
        link_err <= 1'b1;

      // -------- column path --------
      pend_col <= stcp_rise;
      if (stcp_rise) begin
        pend_col_data <= col_sh;
        pend_fs       <= col_sh[0];
      end
      if (ser_rise)
        col_sh <= {col_sh[COL_BITS-2:0], ser_data_s};

      // -------- word path --------
      if (spi_rise)
        lane_sh <= lane_next;

      pend_valid <= wdone;
      pend_err   <= overrun_now | timeout_now;

      if (wdone) begin
        pend_data <= lane_next;
        if (fs_evt) begin
          pend_idx  <= '0;
          pend_done <= 1'b0;
          word_cnt  <= IDX_W'(1);
          wrapped   <= 1'b0;
        end else begin
          pend_idx  <= word_cnt;
          pend_done <= (word_cnt == LAST_WORD);
          if (word_cnt == LAST_WORD) begin
            word_cnt <= '0;
            wrapped  <= 1'b1;
          end else begin
            word_cnt <= word_cnt + IDX_W'(1);
          end
        end
      end else if (fs_evt) begin
        word_cnt <= '0;
        wrapped  <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (spi_rise && !fs_evt && !wdone) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            tmr     <= TMR_LOAD;
            state   <= RECV;
          end else begin
            bit_cnt <= '0;
          end
        end
        RECV: begin
          if (wdone || fs_evt || timeout_now) begin
            bit_cnt <= '0;
            state   <= IDLE;
          end else if (spi_rise) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
            tmr     <= TMR_LOAD;
          end else begin
            tmr <= tmr - TMR_W'(1);
          end
        end
        default: begin
          bit_cnt <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matrix_link_rx.sv
module tb_matrix_link_rx;
  localparam int CN  = 3;
  localparam int SS  = 8;
  localparam int BPM = 384;
  localparam int CB  = 8;
  localparam int TO  = 1024;
  localparam int IW  = $clog2(BPM + 1);

  logic          clk = 1'b0;
  logic          rst;
  logic          spi_clk, ser_clk, ser_data, ser_stcp, ser_n_enable;
  logic [CN-1:0] spi_mosi;
  logic [CN*SS-1:0] data_out;
  logic          data_valid;
  logic [IW-1:0] byte_index;
  logic          frame_start, frame_done, col_valid;
  logic [CB-1:0] col_data;
  logic          link_err, out_enabled;

  matrix_link_rx #(
    .CHANNEL_NUMBER(CN), .SPI_SIZE(SS), .MSB_FIRST(1),
    .BYTES_PER_MATRIX(BPM), .COL_BITS(CB), .IDLE_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .ser_clk(ser_clk), .ser_data(ser_data), .ser_stcp(ser_stcp),
    .ser_n_enable(ser_n_enable), .data_out(data_out), .data_valid(data_valid),
    .byte_index(byte_index), .frame_start(frame_start), .frame_done(frame_done),
    .col_valid(col_valid), .col_data(col_data), .link_err(link_err),
    .out_enabled(out_enabled)
  );

  always #5 clk = ~clk;

  typedef struct { logic [23:0] data; int idx; bit fdone; } word_exp_t;
  typedef struct { logic [7:0] l0; logic [7:0] l1; logic [7:0] l2; logic [23:0] exp; } vec_t;

  word_exp_t     wq[$];
  logic [CB-1:0] cq[$];
  int vectors = 0;
  int miscompares = 0;

  // Reference model: words since the last frame start, expected error flag.
  int m_count = 0;
  bit m_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_fs();
    m_count = 0;
    m_err   = 0;
  endtask

  task automatic model_word(input logic [23:0] d);
    word_exp_t e;
    e.data  = d;
    e.idx   = m_count % BPM;
    e.fdone = ((m_count % BPM) == BPM - 1);
    if (m_count >= BPM) m_err = 1;
    m_count++;
    wq.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic [CN-1:0] b, input bit with_stcp);
    spi_mosi = b;
    tick($urandom_range(2, 3));
    spi_clk = 1'b1;
    if (with_stcp) ser_stcp = 1'b1;
    tick($urandom_range(2, 3));
    spi_clk  = 1'b0;
    ser_stcp = 1'b0;
  endtask

  task automatic shift_col(input logic [CB-1:0] c);
    for (int b = CB - 1; b >= 0; b--) begin
      ser_data = c[b];
      tick(2);
      ser_clk = 1'b1;
      tick(2);
      ser_clk = 1'b0;
    end
  endtask

  task automatic strobe(input logic [CB-1:0] c);
    cq.push_back(c);
    if (c[0]) model_fs();
    ser_stcp = 1'b1;
    tick(3);
    ser_stcp = 1'b0;
    tick(6);
  endtask

  task automatic send_bits(input logic [7:0] l0, l1, l2, input int n);
    for (int b = SS - 1; b >= SS - n; b--) spi_bit({l2[b], l1[b], l0[b]}, 1'b0);
  endtask

  // fs_last: the final bit's clock edge coincides with a frame-start strobe.
  task automatic send_word(input logic [7:0] l0, l1, l2, input logic [23:0] exp, input bit fs_last);
    if (fs_last) begin
      shift_col(8'h03);
      cq.push_back(8'h03);
      model_fs();
    end
    model_word(exp);
    for (int b = SS - 1; b >= 0; b--) spi_bit({l2[b], l1[b], l0[b]}, fs_last && (b == 0));
  endtask

  task automatic check_err(input string name);
    tick(8);
    check(name, link_err, m_err);
  endtask

  // Output monitor: every reported word / column must match the next expectation.
  always @(negedge clk) begin : mon
    word_exp_t we;
    logic [CB-1:0] ce;
    if (!rst) begin
      if (data_valid || frame_done) begin
        if (wq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_word: data_valid=%0b frame_done=%0b data=%0h, none expected", data_valid, frame_done, data_out);
        end else begin
          we = wq.pop_front();
          check("data_valid", data_valid, 1);
          check("word_data", data_out, we.data);
          check("byte_index", byte_index, we.idx);
          check("frame_done", frame_done, we.fdone);
        end
      end
      if (col_valid || frame_start) begin
        if (cq.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_col: col_valid=%0b frame_start=%0b, none expected", col_valid, frame_start);
        end else begin
          ce = cq.pop_front();
          check("col_valid", col_valid, 1);
          check("col_data", col_data, ce);
          check("frame_start", frame_start, ce[0]);
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[6];
  logic [7:0] r0, r1, r2;

  initial begin
    tbl[0] = '{8'hFF, 8'h00, 8'hA5, 24'hA500FF};
    tbl[1] = '{8'h12, 8'h34, 8'h56, 24'h563412};
    tbl[2] = '{8'h80, 8'h01, 8'h7E, 24'h7E0180};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 24'h000000};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
    tbl[5] = '{8'h3C, 8'hC3, 8'h99, 24'h99C33C};

    rst = 1'b1;
    spi_clk = 0; spi_mosi = '0; ser_clk = 0; ser_data = 0; ser_stcp = 0; ser_n_enable = 1;
    tick(3);
    check("rst_data_out", data_out, 0);
    check("rst_data_valid", data_valid, 0);
    check("rst_byte_index", byte_index, 0);
    check("rst_col_data", col_data, 0);
    check("rst_link_err", link_err, 0);
    check("rst_out_enabled", out_enabled, 0);
    rst = 1'b0;
    tick(3);

    // Column 0x01 then strobe: col_valid/frame_start exactly 3+1 clk later.
    shift_col(8'h01);
    cq.push_back(8'h01);
    model_fs();
    @(negedge clk) ser_stcp = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("col_valid_early", col_valid, 0);
    check("frame_start_early", frame_start, 0);
    @(posedge clk);
    #1 check("col_valid_on_time", col_valid, 1);
    check("frame_start_on_time", frame_start, 1);
    check("col_data_on_time", col_data, 8'h01);
    @(posedge clk);
    #1 check("col_valid_single", col_valid, 0);
    @(negedge clk) ser_stcp = 1'b0;
    tick(4);

    // Output enable follows inverted ser_n_enable.
    ser_n_enable = 0;
    tick(5);
    check("out_enabled_on", out_enabled, 1);

    // Table vectors, first word after frame start lands on index 0.
    for (int i = 0; i < 6; i++) send_word(tbl[i].l0, tbl[i].l1, tbl[i].l2, tbl[i].exp, 1'b0);
    check_err("err_after_table");

    // Frame start coinciding with a completed word.
    send_word(8'h11, 8'h22, 8'h33, 24'h332211, 1'b1);
    send_word(8'h44, 8'h55, 8'h66, 24'h665544, 1'b0);
    check_err("err_after_fs_same_cycle");

    // Full random frame, words received with outputs disabled part of the time.
    shift_col(8'h01);
    strobe(8'h01);
    ser_n_enable = 1;
    tick(5);
    check("out_enabled_off", out_enabled, 0);
    for (int i = 0; i < BPM; i++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom);
      if (i == BPM / 2) ser_n_enable = 0;
      send_word(r0, r1, r2, {r2, r1, r0}, 1'b0);
    end
    check_err("err_after_full_frame");

    // Overrun: another word without frame start.
    send_word(8'hA1, 8'hB2, 8'hC3, 24'hC3B2A1, 1'b0);
    check_err("err_overrun");
    shift_col(8'h01);
    strobe(8'h01);
    check_err("err_cleared_by_fs");

    // Idle timeout on a partial word.
    send_bits(8'hFF, 8'hFF, 8'hFF, 3);
    tick(900);
    check("err_before_timeout", link_err, 0);
    tick(200);
    m_err = 1;
    check("err_after_timeout", link_err, m_err);
    send_word(8'h12, 8'h34, 8'h56, 24'h563412, 1'b0);
    check_err("err_sticky_after_clean_word");

    // Reset mid-word.
    send_bits(8'hFF, 8'h0F, 8'hF0, 5);
    @(negedge clk) rst = 1'b1;
    #1;
    check("midrst_data_out", data_out, 0);
    check("midrst_byte_index", byte_index, 0);
    check("midrst_col_data", col_data, 0);
    check("midrst_link_err", link_err, 0);
    check("midrst_data_valid", data_valid, 0);
    tick(3);
    rst = 1'b0;
    m_count = 0;
    m_err = 0;
    tick(3);
    send_word(8'h5A, 8'h6B, 8'h7C, 24'h7C6B5A, 1'b0);
    check_err("err_after_reset_word");

    tick(20);
    check("words_outstanding", wq.size(), 0);
    check("cols_outstanding", cq.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
